pipelined_decode_unit: RTL and testbench
========================================

# pipelined_decode_unit

Parametrised instruction-decode stage with an integrated ID/EX pipeline register. It sits between the fetch stage and the execute stage. It extracts instruction fields, reads a parametrised register file with write-back bypass, and forms immediates and the jump target. It also detects load-use hazards and registers everything for EX with valid, hold and flush control.

## Interface
- XLEN, 32, datapath and register width (≥ 32)
- NREG, 32, number of architectural registers (power of two, ≤ 32); AW = $clog2(NREG)
- CTRL_W, 20, width of the control word from the external controller
- MEMREAD_BIT, 0, index of MemRead inside the control word
- Clk  in  1  clock, all state updates on rising edge
- Rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  Instruction_in/PC_in hold a real instruction
- Instruction_in  in  32  instruction word
- PC_in  in  XLEN  PC+4 of the instruction
- ctrl_in  in  CTRL_W  control word for Instruction_in (combinational from controller)
- hold_in  in  1  downstream stall; freeze the whole stage
- flush_in  in  1  squash the instruction in decode (taken branch/jump)
- RegWrite_in  in  1  write-back enable
- WriteRegDst_in  in  AW  write-back register address
- WriteData_in  in  XLEN  write-back data
- stall_out  out  1  load-use stall request to fetch (hold PC and Instruction_in)
- jump_target  out  XLEN  {PC_in[XLEN-1:28], Instruction_in[25:0], 2'b00}, combinational
- ex_valid  out  1  EX-stage slot valid
- ex_ctrl  out  CTRL_W  registered control word
- ex_rs_data, ex_rt_data  out  XLEN  registered operands
- ex_rs_addr, ex_rt_addr, ex_rd_addr  out  AW  registered register addresses (low AW bits of fields)
- ex_sign_ext, ex_zero_ext  out  XLEN  registered extended imm[15:0]
- ex_pc  out  XLEN  registered PC_in

## Operation
- Fields: rs = instr[25:21], rt = instr[20:16], rd = instr[15:11], imm = instr[15:0]. Addresses are truncated to AW bits.
- Register file:
  - NREG×XLEN array, written on the rising edge when RegWrite_in=1 and WriteRegDst_in≠0.
  - Register 0 reads as 0 and is never written.
- Read bypass:
  - Applies when RegWrite_in=1, WriteRegDst_in≠0 and WriteRegDst_in equals the read address.
  - The read returns WriteData_in in the same cycle, so write-before-read holds within one cycle.
- Load-use hazard: `lu` = in_valid & ex_valid & ex_ctrl[MEMREAD_BIT] & ex_rt_addr≠0 & (ex_rt_addr==rs | ex_rt_addr==rt).
- stall_out = lu & ~flush_in & ~hold_in.
- ID/EX update, evaluated in priority order per cycle:
  1. hold_in=1: all ex_* keep their values. The register file still accepts writes. stall_out=0, because fetch is held by the same hold.
  2. flush_in=1: ex_valid←0, ex_ctrl←0, other ex_* don't-care (loaded normally).
  3. lu=1: bubble, ex_valid←0, ex_ctrl←0. The decoded instruction is retried next cycle with the same Instruction_in.
  4. Otherwise: ex_valid←in_valid, ex_ctrl←in_valid ? ctrl_in : 0, and all data and address fields are loaded.
- Sign extension replicates imm[15] to XLEN. Zero extension pads with 0.

## Timing
- Decode to EX latency is 1 cycle: an instruction presented in cycle n appears on ex_* in cycle n+1.
- A load-use stall lasts exactly one cycle. The bubble's ex_valid=0 clears `lu` on the next cycle.
- stall_out and jump_target are combinational from the current-cycle inputs and ID/EX state.
- Rst low, asynchronously:
  - ex_valid=0, ex_ctrl=0, and every ex_* data/address output is 0.
  - All registers are 0, so stall_out=0.
  - An instruction in flight is discarded.
  - The first update occurs on the first rising edge after Rst deasserts.
- Simultaneous write-back and read of the same register: the bypass value wins.
- Simultaneous flush_in and lu: flush wins and stall_out=0.

## Structure
- Shared package: field bit positions (OP/RS/RT/RD/IMM), the jump-target split constant (28), and a reset value constant for the ex bundle.
- Sub-module regfile_bypass: the parametrised NREG×XLEN array with async-low reset, a write port, two read ports and same-cycle bypass.
- Hazard logic and the ID/EX register stay in the top level.

## Test plan
- Reset mid-stream: Rst low while ex_valid=1 → ex_valid=0, ex_ctrl=0, and r5 reads 0 after release.
- Bypass: RegWrite_in=1 with dst=7 and data=0xDEADBEEF, decode rs=7 in the same cycle → ex_rs_data=0xDEADBEEF next cycle.
- r0 protection: write 0x1234 to r0, then read r0 → ex_rs_data=0.
- Load-use: lw r3 in EX (ctrl[MEMREAD_BIT]=1), then add rs=3 in decode → stall_out=1 for one cycle and ex_valid=0 bubble. The add reaches EX two cycles after the lw.
- Priority: lu and flush_in together → stall_out=0 and ex_valid=0. hold_in=1 for 3 cycles → ex_* unchanged while a write to r9 still lands.
- Immediates and jump: instr imm=0x8001 with PC_in=0x4000_0010 and target field 0x0000100 → ex_sign_ext=0xFFFF8001, ex_zero_ext=0x00008001, jump_target=0x4000_0400.

Source files
------------

// File: rtl/pipelined_decode_unit_pkg.sv
// pipelined_decode_unit_pkg: instruction field positions and ID/EX reset value
package pipelined_decode_unit_pkg;
    localparam int OP_LSB   = 26;
    localparam int RS_LSB   = 21;
    localparam int RT_LSB   = 16;
    localparam int RD_LSB   = 11;
    localparam int IMM_LSB  = 0;
    localparam int IMM_W    = 16;
    localparam int TGT_W    = 26;
    localparam int JT_SPLIT = 28;
    localparam logic EX_RST = 1'b0;
endpackage

// File: rtl/pipelined_decode_unit_regfile_bypass.sv
// regfile_bypass: NREG x XLEN register file, r0 hardwired to zero, write-back bypass on both read ports
module regfile_bypass #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_a_i,
    input  logic [AW-1:0]   raddr_b_i,
    output logic [XLEN-1:0] rdata_a_o,
    output logic [XLEN-1:0] rdata_b_o
);
    logic [XLEN-1:0] mem_q [NREG];
    logic            wr_en;

    assign wr_en = we_i && (waddr_i != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : (wr_en && waddr_i == raddr_a_i) ? wdata_i : mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : (wr_en && waddr_i == raddr_b_i) ? wdata_i : mem_q[raddr_b_i];
endmodule

// File: rtl/pipelined_decode_unit.sv
// pipelined_decode_unit: decode stage with register read, immediates, jump target,
// load-use detection and the ID/EX pipeline register.
module pipelined_decode_unit
    import pipelined_decode_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NREG        = 32,
    parameter int CTRL_W      = 20,
    parameter int MEMREAD_BIT = 0,
    localparam int AW = $clog2(NREG)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    input  logic [31:0]       Instruction_in,
    input  logic [XLEN-1:0]   PC_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              hold_in,
    input  logic              flush_in,
    input  logic              RegWrite_in,
    input  logic [AW-1:0]     WriteRegDst_in,
    input  logic [XLEN-1:0]   WriteData_in,
    output logic              stall_out,
    output logic [XLEN-1:0]   jump_target,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_rs_data,
    output logic [XLEN-1:0]   ex_rt_data,
    output logic [AW-1:0]     ex_rs_addr,
    output logic [AW-1:0]     ex_rt_addr,
    output logic [AW-1:0]     ex_rd_addr,
    output logic [XLEN-1:0]   ex_sign_ext,
    output logic [XLEN-1:0]   ex_zero_ext,
    output logic [XLEN-1:0]   ex_pc
);
    logic [AW-1:0]     rs, rt, rd;
    logic [IMM_W-1:0]  imm;
    logic [XLEN-1:0]   rs_data, rt_data;
    logic              lu, ex_valid_d;
    logic [CTRL_W-1:0] ex_ctrl_d;
    logic              ex_valid_q;
    logic [CTRL_W-1:0] ex_ctrl_q;
    logic [XLEN-1:0]   ex_rs_data_q, ex_rt_data_q, ex_sign_ext_q, ex_zero_ext_q, ex_pc_q;
    logic [AW-1:0]     ex_rs_addr_q, ex_rt_addr_q, ex_rd_addr_q;
    logic              unused_instr;

    assign rs  = Instruction_in[RS_LSB +: AW];
    assign rt  = Instruction_in[RT_LSB +: AW];
    assign rd  = Instruction_in[RD_LSB +: AW];
    assign imm = Instruction_in[IMM_LSB +: IMM_W];
    assign unused_instr = &{1'b0, Instruction_in[31:OP_LSB]};
    assign jump_target = {PC_in[XLEN-1:JT_SPLIT], Instruction_in[TGT_W-1:0], 2'b00};

    regfile_bypass #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk_i     (Clk),
        .rst_ni    (Rst),
        .we_i      (RegWrite_in),
        .waddr_i   (WriteRegDst_in),
        .wdata_i   (WriteData_in),
        .raddr_a_i (rs),
        .raddr_b_i (rt),
        .rdata_a_o (rs_data),
        .rdata_b_o (rt_data)
    );

    // A load in EX whose destination feeds this instruction forces a one-cycle bubble
    assign lu = in_valid && ex_valid_q && ex_ctrl_q[MEMREAD_BIT] && (ex_rt_addr_q != '0)
                && (ex_rt_addr_q == rs || ex_rt_addr_q == rt);
    assign stall_out  = lu && !flush_in && !hold_in;
    assign ex_valid_d = in_valid && !flush_in && !lu;
    assign ex_ctrl_d  = ex_valid_d ? ctrl_in : '0;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ex_valid_q    <= EX_RST;
            ex_ctrl_q     <= {CTRL_W{EX_RST}};
            ex_rs_data_q  <= {XLEN{EX_RST}};
            ex_rt_data_q  <= {XLEN{EX_RST}};
            ex_rs_addr_q  <= {AW{EX_RST}};
            ex_rt_addr_q  <= {AW{EX_RST}};
            ex_rd_addr_q  <= {AW{EX_RST}};
            ex_sign_ext_q <= {XLEN{EX_RST}};
            ex_zero_ext_q <= {XLEN{EX_RST}};
            ex_pc_q       <= {XLEN{EX_RST}};
        end else if (!hold_in) begin
            ex_valid_q    <= ex_valid_d;
            ex_ctrl_q     <= ex_ctrl_d;
            ex_rs_data_q  <= rs_data;
            ex_rt_data_q  <= rt_data;
            ex_rs_addr_q  <= rs;
            ex_rt_addr_q  <= rt;
            ex_rd_addr_q  <= rd;
            ex_sign_ext_q <= {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
            ex_zero_ext_q <= {{(XLEN-IMM_W){1'b0}}, imm};
            ex_pc_q       <= PC_in;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign ex_rs_data  = ex_rs_data_q;
    assign ex_rt_data  = ex_rt_data_q;
    assign ex_rs_addr  = ex_rs_addr_q;
    assign ex_rt_addr  = ex_rt_addr_q;
    assign ex_rd_addr  = ex_rd_addr_q;
    assign ex_sign_ext = ex_sign_ext_q;
    assign ex_zero_ext = ex_zero_ext_q;
    assign ex_pc       = ex_pc_q;
endmodule

// File: tb/tb_pipelined_decode_unit.sv
// tb_pipelined_decode_unit: directed stimulus with an expectation queue drained by an EX-stage monitor
module tb_pipelined_decode_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, hold, flush, rw;
    logic [31:0] instr, pc, wdata;
    logic [19:0] ctrl;
    logic [4:0]  wdst;
    logic        stall_out, ex_valid;
    logic [31:0] jump_target, ex_rs_data, ex_rt_data, ex_sign_ext, ex_zero_ext, ex_pc;
    logic [19:0] ex_ctrl;
    logic [4:0]  ex_rs_addr, ex_rt_addr, ex_rd_addr;

    typedef struct {
        logic [19:0] ctrl;
        logic [31:0] rs_d, rt_d, sx, zx, pc;
        logic [4:0]  rs, rt, rd;
    } exp_t;

    exp_t        q[$];
    exp_t        pe, me;
    logic [31:0] rf_m [32];
    int          cmp = 0;
    int          err = 0;
    bit          ld;

    always #5 clk = ~clk;

    pipelined_decode_unit dut (
        .Clk(clk), .Rst(rst_n), .in_valid(in_valid), .Instruction_in(instr), .PC_in(pc),
        .ctrl_in(ctrl), .hold_in(hold), .flush_in(flush), .RegWrite_in(rw),
        .WriteRegDst_in(wdst), .WriteData_in(wdata), .stall_out(stall_out),
        .jump_target(jump_target), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_rs_addr(ex_rs_addr),
        .ex_rt_addr(ex_rt_addr), .ex_rd_addr(ex_rd_addr), .ex_sign_ext(ex_sign_ext),
        .ex_zero_ext(ex_zero_ext), .ex_pc(ex_pc)
    );

    function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    function automatic logic [31:0] rdm(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : (rw && wdst == a) ? wdata : rf_m[a];
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        cmp++;
        if (a !== e) begin
            err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
        end
    endtask

    task automatic step(input bit push);
        if (push) begin
            pe.ctrl = ctrl;
            pe.rs   = instr[25:21];
            pe.rt   = instr[20:16];
            pe.rd   = instr[15:11];
            pe.rs_d = rdm(instr[25:21]);
            pe.rt_d = rdm(instr[20:16]);
            pe.sx   = {{16{instr[15]}}, instr[15:0]};
            pe.zx   = {16'h0, instr[15:0]};
            pe.pc   = pc;
            q.push_back(pe);
        end
        @(posedge clk);
        if (rw && wdst != 5'd0 && rst_n) rf_m[wdst] = wdata;
        #1;
    endtask

    // Monitor: every freshly loaded valid EX slot must match the oldest expectation
    initial forever begin
        @(posedge clk);
        ld = !hold && rst_n;
        @(negedge clk);
        if (ld && ex_valid) begin
            cmp++;
            if (q.size() == 0) begin
                err++;
                $display("FAIL unexpected_ex: ex_pc=0x%08h ex_ctrl=0x%05h with empty queue", ex_pc, ex_ctrl);
            end else begin
                me = q.pop_front();
                if (ex_ctrl !== me.ctrl || ex_rs_data !== me.rs_d || ex_rt_data !== me.rt_d ||
                    ex_rs_addr !== me.rs || ex_rt_addr !== me.rt || ex_rd_addr !== me.rd ||
                    ex_sign_ext !== me.sx || ex_zero_ext !== me.zx || ex_pc !== me.pc) begin
                    err++;
                    $display("FAIL ex_bundle: got ctrl=%05h rs=%08h rt=%08h a=%0d/%0d/%0d sx=%08h zx=%08h pc=%08h expected ctrl=%05h rs=%08h rt=%08h a=%0d/%0d/%0d sx=%08h zx=%08h pc=%08h",
                        ex_ctrl, ex_rs_data, ex_rt_data, ex_rs_addr, ex_rt_addr, ex_rd_addr, ex_sign_ext, ex_zero_ext, ex_pc,
                        me.ctrl, me.rs_d, me.rt_d, me.rs, me.rt, me.rd, me.sx, me.zx, me.pc);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; hold = 1'b0; flush = 1'b0; rw = 1'b0;
        instr = '0; pc = '0; ctrl = '0; wdst = '0; wdata = '0;
        for (int i = 0; i < 32; i++) rf_m[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ctrl", {12'd0, ex_ctrl}, 32'd0);
        chk("rst_rs_data", ex_rs_data, 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        rst_n = 1'b1;
        rw = 1'b1; wdst = 5'd5; wdata = 32'h55; step(0);
        wdst = 5'd3; wdata = 32'h33; step(0);
        wdst = 5'd7; wdata = 32'hDEADBEEF; in_valid = 1'b1;
        instr = ins(6'h0, 5'd7, 5'd5, 16'h2020); pc = 32'h100; ctrl = 20'h2; step(1);
        chk("bypass_rs", ex_rs_data, 32'hDEADBEEF);
        in_valid = 1'b0; wdst = 5'd0; wdata = 32'h1234; step(0);
        rw = 1'b0; in_valid = 1'b1;
        instr = ins(6'h0, 5'd0, 5'd3, 16'h0); pc = 32'h104; ctrl = 20'h4; step(1);
        chk("r0_read", ex_rs_data, 32'd0);
        chk("r3_read", ex_rt_data, 32'h33);
        instr = ins(6'h08, 5'd5, 5'd3, 16'h8001); pc = 32'h4000_0010; ctrl = 20'h8; step(1);
        chk("sign_ext", ex_sign_ext, 32'hFFFF_8001);
        chk("zero_ext", ex_zero_ext, 32'h0000_8001);
        in_valid = 1'b0; instr = {6'h02, 26'h0000100}; #1;
        chk("jump_a", jump_target, 32'h4000_0400);
        pc = 32'hF000_0000; instr = {6'h02, 26'h3FFFFFF}; #1;
        chk("jump_b", jump_target, 32'hFFFF_FFFC);
        in_valid = 1'b1; instr = ins(6'h23, 5'd5, 5'd3, 16'h4); pc = 32'h200; ctrl = 20'h1; step(1);
        instr = ins(6'h0, 5'd3, 5'd5, 16'h1820); pc = 32'h204; ctrl = 20'h10; #1;
        chk("lu_stall", {31'd0, stall_out}, 32'd1);
        step(0);
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_ctrl", {12'd0, ex_ctrl}, 32'd0);
        chk("lu_one_cycle", {31'd0, stall_out}, 32'd0);
        step(1);
        instr = ins(6'h23, 5'd5, 5'd0, 16'h8); pc = 32'h208; ctrl = 20'h1; step(1);
        instr = ins(6'h0, 5'd0, 5'd0, 16'h0); pc = 32'h20C; ctrl = 20'h10; #1;
        chk("lu_r0_nostall", {31'd0, stall_out}, 32'd0);
        step(1);
        instr = ins(6'h23, 5'd5, 5'd3, 16'hC); pc = 32'h210; ctrl = 20'h1; step(1);
        instr = ins(6'h0, 5'd3, 5'd3, 16'h1820); pc = 32'h214; ctrl = 20'h10; flush = 1'b1; #1;
        chk("flush_lu_stall", {31'd0, stall_out}, 32'd0);
        step(0);
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_ctrl", {12'd0, ex_ctrl}, 32'd0);
        flush = 1'b0;
        instr = ins(6'h23, 5'd5, 5'd3, 16'h10); pc = 32'h300; ctrl = 20'hABCD; step(1);
        hold = 1'b1; rw = 1'b1; wdst = 5'd9; wdata = 32'h99;
        instr = ins(6'h0, 5'd3, 5'd0, 16'h0); pc = 32'h304; ctrl = 20'h10; #1;
        chk("hold_lu_stall", {31'd0, stall_out}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(0);
            chk("hold_ctrl", {12'd0, ex_ctrl}, 32'hABCD);
            chk("hold_pc", ex_pc, 32'h300);
            instr = ins(6'h0, 5'd9, 5'd0, 16'h0);
        end
        hold = 1'b0; rw = 1'b0;
        instr = ins(6'h0, 5'd9, 5'd0, 16'h4800); pc = 32'h308; ctrl = 20'h20; step(1);
        chk("r9_written_in_hold", ex_rs_data, 32'h99);
        @(negedge clk);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 32; i++) rf_m[i] = '0;
        #1;
        chk("midrst_valid", {31'd0, ex_valid}, 32'd0);
        chk("midrst_ctrl", {12'd0, ex_ctrl}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        instr = ins(6'h0, 5'd5, 5'd7, 16'h0); pc = 32'h400; ctrl = 20'h40; step(1);
        chk("r5_after_rst", ex_rs_data, 32'd0);
        in_valid = 1'b0;
        repeat (3) step(0);
        chk("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
